// File: rtl/noc_flit_pkg.sv
// Shared flit definitions for the Hamming-protected flit encoder/decoder pair.
package noc_flit_pkg;

  // Only flits tagged with this selector carry core data.
  localparam logic [1:0] CTRL_CORE = 2'd2;

  localparam int FLIT_W = 11;
  localparam int IP_W   = 4;
  localparam int CW_W   = 7;

  // Field positions inside a flit: IP in the low nibble, codeword above it.
  localparam int IP_LSB = 0;
  localparam int IP_MSB = IP_LSB + IP_W - 1;
  localparam int CW_LSB = IP_W;
  localparam int CW_MSB = CW_LSB + CW_W - 1;

  // Decoder result: syndrome plus the codeword after single-bit repair.
  typedef struct packed {
    logic [2:0]      syndrome;
    logic [CW_W-1:0] cw;
  } hamming_dec_t;

  // Hamming(7,4) decode; any nonzero syndrome is taken as the 1-based
  // position of a single flipped bit (double errors are not detected).
  function automatic hamming_dec_t hamming74_decode(input logic [CW_W-1:0] cw);
    hamming_dec_t r;
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    r.syndrome = {s4, s2, s1};
    r.cw       = cw;
    if (r.syndrome != 3'd0) begin
      r.cw = cw ^ (7'd1 << (r.syndrome - 3'd1));
    end
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head entry is visible
// combinationally so the consumer can decode it before popping.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers share the low bits when full or empty; the extra wrap bit tells them apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer update; push and pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage has no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/flit_rx_decoder.sv
// Receive endpoint: filters flits by selector, buffers core flits, repairs
// single-bit codeword errors and presents the recovered byte downstream.
module flit_rx_decoder
  import noc_flit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FLIT_W-1:0]         in_flit,
  input  logic [1:0]                in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_corrected,
  output logic [CNT_W-1:0]          corr_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  logic              fifo_full;
  logic              fifo_empty;
  logic [FLIT_W-1:0] head_flit;
  logic              accept;
  logic              push;
  logic              drop;
  logic              load;
  hamming_dec_t      head_dec;

  // in_ready comes from registered FIFO state only, so a same-cycle pop never opens a slot.
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_ctrl == CTRL_CORE);
  assign drop     = accept && (in_ctrl != CTRL_CORE);
  assign load     = !fifo_empty && (!out_valid || out_ready);
  assign head_dec = hamming74_decode(head_flit[CW_MSB:CW_LSB]);

  flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_flit),
    .pop       (load),
    .pop_data  (head_flit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Output register: load the decoded head when free or being consumed, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_data      <= {head_dec.cw[6], head_dec.cw[5], head_dec.cw[4], head_dec.cw[2],
                        head_flit[IP_MSB:IP_LSB]};
      out_corrected <= (head_dec.syndrome != 3'd0);
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Saturating statistics: corrections counted when a byte is loaded, drops when accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (load && (head_dec.syndrome != 3'd0) && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flit_rx_decoder.sv
// Self-checking bench for flit_rx_decoder: directed steps with randomized
// flits, scored against a position-based Hamming reference model.
module tb_flit_rx_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_flit = '0;
  logic [1:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_corrected;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  int model_corr = 0;
  int model_drop = 0;

  flit_rx_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flit(in_flit), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_corrected(out_corrected),
    .corr_cnt(corr_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: syndrome is the XOR of the 1-based positions of all set bits.
  function automatic logic [8:0] ref_decode(input logic [10:0] f);
    logic [6:0] cw;
    int syn;
    cw = f[10:4];
    syn = 0;
    for (int pos = 1; pos <= 7; pos++) if (cw[pos-1]) syn = syn ^ pos;
    if (syn != 0) cw[syn-1] = ~cw[syn-1];
    return {(syn != 0), cw[6], cw[5], cw[4], cw[2], f[3:0]};
  endfunction

  // Encode a nibble: data at positions 3,5,6,7, parity chosen to zero the syndrome.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] cw;
    int syn;
    cw = '0;
    cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
    syn = 0;
    for (int pos = 1; pos <= 7; pos++) if (cw[pos-1]) syn = syn ^ pos;
    cw[0] = syn[0]; cw[1] = syn[1]; cw[3] = syn[2];
    return cw;
  endfunction

  function automatic logic [10:0] rand_corrupt_flit();
    logic [6:0] cw;
    cw = ref_encode(4'($urandom_range(0, 15)));
    cw = cw ^ (7'd1 << $urandom_range(0, 6));
    return {cw, 4'($urandom_range(0, 15))};
  endfunction

  // Scoreboard: score deliveries and record acceptances just before each edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_corrected", 32'(out_corrected), 32'(e[8]));
        end
      end
      if (in_valid && in_ready) begin
        if (in_ctrl == 2'd2) begin
          logic [8:0] e;
          e = ref_decode(in_flit);
          exp_q.push_back(e);
          if (e[8] && model_corr < 255) model_corr++;
        end else if (model_drop < 255) begin
          model_drop++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] f, input logic [1:0] c);
    bit done;
    done = 0;
    in_valid = 1'b1; in_flit = f; in_ctrl = c;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1;
      else tick();
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic latency_test(input logic [10:0] f, input string tag);
    logic [8:0] e;
    e = ref_decode(f);
    out_ready = 1'b1;
    in_valid = 1'b1; in_flit = f; in_ctrl = 2'd2;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid_after_n"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid_after_n1"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(e[7:0]));
    tick();
    check({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] bp_flit [6];
    int accepted, stalls, bubbles;
    logic [7:0] held;

    // Step 1: reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_corrected", 32'(out_corrected), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Step 2: clean flit with exact latency and known byte
    latency_test(11'h525, "clean");
    check("clean_byte_const", 32'(ref_decode(11'h525)), 32'h0A5);
    check("clean_corr_cnt", 32'(corr_cnt), 32'd0);

    // Step 3: single-bit flips at every flit position
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) send(11'h525 ^ (11'd1 << k), 2'd2);
    wait_drain();
    check("single_err_corr_cnt", 32'(corr_cnt), 32'(model_corr));
    check("single_err_corr_is_7", 32'(model_corr), 32'd7);

    // Step 4: non-core selectors are dropped
    send(11'h525, 2'd0);
    send(11'h525, 2'd1);
    send(11'h525, 2'd3);
    tick(); tick();
    check("drop_out_valid", 32'(out_valid), 32'd0);
    check("drop_fifo_level", 32'(fifo_level), 32'd0);
    check("drop_cnt", 32'(drop_cnt), 32'(model_drop));
    check("drop_cnt_is_3", 32'(drop_cnt), 32'd3);

    // Step 5: backpressure fills FIFO plus output register
    for (int i = 0; i < 6; i++) bp_flit[i] = 11'($urandom_range(0, 2047));
    out_ready = 1'b0;
    accepted = 0;
    in_valid = 1'b1; in_ctrl = 2'd2;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_flit = bp_flit[accepted];
      if (in_ready) accepted++;
      tick();
    end
    check("bp_accepted", 32'(accepted), 32'd5);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_fifo_level", 32'(fifo_level), 32'(DEPTH));
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held = out_data;
    check("bp_head_data", 32'(out_data), 32'(ref_decode(bp_flit[0]) & 9'hFF));
    tick(); tick(); tick();
    check("bp_still_blocked", 32'(in_ready), 32'd0);
    check("bp_data_stable", 32'(out_data), 32'(held));
    out_ready = 1'b1;
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        if (in_ready) done = 1;
        tick();
      end
      check("bp_sixth_accepted", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    wait_drain();

    // Step 6: 300 corrupted flits streamed, counter saturates, no bubbles
    stalls = 0; bubbles = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 2'd2;
    for (int i = 0; i < 300; i++) begin
      in_flit = rand_corrupt_flit();
      if (!in_ready) stalls++;
      tick();
      if (i >= 1 && !out_valid) bubbles++;
    end
    in_valid = 1'b0;
    tick();
    check("stream_last_valid", 32'(out_valid), 32'd1);
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_bubbles", 32'(bubbles), 32'd0);
    wait_drain();
    check("sat_corr_cnt", 32'(corr_cnt), 32'(model_corr));
    check("sat_corr_is_255", 32'(corr_cnt), 32'd255);

    // Step 7: asynchronous reset with flits buffered and held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(11'($urandom_range(0, 2047)), 2'd2);
    check("pre_rst_level", 32'(fifo_level), 32'd3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_corr = 0;
    model_drop = 0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_corr", 32'(corr_cnt), 32'd0);
    check("async_rst_drop", 32'(drop_cnt), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    latency_test(rand_corrupt_flit(), "post_rst");
    check("post_rst_corr_cnt", 32'(corr_cnt), 32'(model_corr));
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
